// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter that shares one dispense motor and one change unit among NLANE vend lanes.
// Keeps per-lane stock, refuses vends from empty lanes and parks in FAULT on a mechanism timeout.
module vend_dispense_arbiter #(
    parameter int NLANE      = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10,
    parameter int TIMEOUT    = 15,
    localparam int LW        = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NLANE-1:0] vend_req,
    input  logic [NLANE-1:0] vend_chg,
    output logic             motor_go,
    output logic [LW-1:0]    motor_lane,
    input  logic             motor_done,
    output logic             chg_go,
    input  logic             chg_done,
    output logic [NLANE-1:0] served,
    output logic [NLANE-1:0] refund,
    output logic [NLANE-1:0] empty,
    input  logic             restock_stb,
    input  logic [LW-1:0]    restock_lane,
    output logic             fault,
    input  logic             fault_clr,
    output logic             busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISP,
        S_CHG,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             state, state_n;
    logic [NLANE-1:0]   pend, pend_n, pend_chg, pend_chg_n;
    logic [NLANE-1:0]   accept, refuse;
    logic [LW-1:0]      cur, last, grant_lane;
    logic               grant_found;
    logic [TW-1:0]      tmo_cnt;
    logic               tmo_hit;
    logic [STOCK_W-1:0] stock [NLANE];

    // First pending lane after the most recently served one, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_lane  = '0;
        for (int k = 1; k <= NLANE; k++) begin
            if (!grant_found && pend[(int'(last) + k) % NLANE]) begin
                grant_found = 1'b1;
                grant_lane  = LW'((int'(last) + k) % NLANE);
            end
        end
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    // Handshake: a go output is a level held while its state is active; the matching done is
    // sampled only in that state and ends it at the next edge, winning over a same-cycle timeout.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (grant_found) state_n = S_DISP;
            S_DISP: begin
                if (motor_done)   state_n = pend_chg[cur] ? S_CHG : S_DONE;
                else if (tmo_hit) state_n = S_FAULT;
            end
            S_CHG: begin
                if (chg_done)     state_n = S_DONE;
                else if (tmo_hit) state_n = S_FAULT;
            end
            S_DONE:  state_n = S_IDLE;
            S_FAULT: if (fault_clr) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // A lane that is still pending (including cur during DONE) ignores new requests.
    always_comb begin
        pend_n     = pend;
        pend_chg_n = pend_chg;
        accept     = '0;
        refuse     = '0;
        if (state == S_DONE) begin
            pend_n[cur]     = 1'b0;
            pend_chg_n[cur] = 1'b0;
        end
        for (int i = 0; i < NLANE; i++) begin
            accept[i] = vend_req[i] && !pend[i] && (stock[i] != '0);
            refuse[i] = vend_req[i] && !pend[i] && (stock[i] == '0);
            if (accept[i]) begin
                pend_n[i]     = 1'b1;
                pend_chg_n[i] = vend_chg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_chg <= '0;
            cur      <= '0;
            last     <= LW'(NLANE - 1);
            refund   <= '0;
            tmo_cnt  <= '0;
            for (int i = 0; i < NLANE; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            if (state_n != state)                      tmo_cnt <= '0;
            else if (state == S_DISP || state == S_CHG) tmo_cnt <= tmo_cnt + 1'b1;
            if (state == S_IDLE && grant_found) cur  <= grant_lane;
            if (state == S_DONE)                last <= cur;
            pend     <= pend_n;
            pend_chg <= pend_chg_n;
            refund   <= refuse;
            // Stock counts pending vends; a same-lane restock overrides the decrement.
            for (int i = 0; i < NLANE; i++) begin
                if (restock_stb && restock_lane == LW'(i)) stock[i] <= STOCK_W'(STOCK_INIT);
                else if (accept[i])                        stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

    always_comb begin
        served = '0;
        empty  = '0;
        if (state == S_DONE) served[cur] = 1'b1;
        for (int i = 0; i < NLANE; i++) empty[i] = (stock[i] == '0);
    end

    assign motor_go   = (state == S_DISP);
    assign chg_go     = (state == S_CHG);
    assign fault      = (state == S_FAULT);
    assign busy       = (state != S_IDLE);
    assign motor_lane = cur;

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench for vend_dispense_arbiter: a transaction-level model of lanes, stock and the
// shared mechanism is checked every cycle, plus a served-order scoreboard and literal checks.
module tb_vend_dispense_arbiter;
    localparam int NLANE      = 4;
    localparam int LW         = 2;
    localparam int STOCK_INIT = 10;
    localparam int TIMEOUT    = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [NLANE-1:0] vend_req, vend_chg;
    logic             motor_go, motor_done, chg_go, chg_done;
    logic [LW-1:0]    motor_lane, restock_lane;
    logic [NLANE-1:0] served, refund, empty;
    logic             restock_stb, fault, fault_clr, busy;

    vend_dispense_arbiter #(
        .NLANE(NLANE), .STOCK_W(4), .STOCK_INIT(STOCK_INIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .vend_req(vend_req), .vend_chg(vend_chg),
        .motor_go(motor_go), .motor_lane(motor_lane), .motor_done(motor_done),
        .chg_go(chg_go), .chg_done(chg_done), .served(served), .refund(refund),
        .empty(empty), .restock_stb(restock_stb), .restock_lane(restock_lane),
        .fault(fault), .fault_clr(fault_clr), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [LW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_MOTOR, M_CHANGE, M_FINISH, M_FAULT} act_t;
    act_t             m_act;
    int               m_stock [NLANE];
    bit               m_pend  [NLANE];
    bit               m_chg   [NLANE];
    int               m_last, m_owner, m_waited;
    logic [NLANE-1:0] m_refund, m_acc, m_ref;
    bit               model_valid = 1'b0, found;
    int               lane_k;
    logic             x_motor_go, x_chg_go, x_fault, x_busy;
    logic [NLANE-1:0] x_served, x_empty;

    function automatic bit model_has_pend();
        for (int i = 0; i < NLANE; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NLANE; i++) begin
                m_stock[i] = STOCK_INIT; m_pend[i] = 1'b0; m_chg[i] = 1'b0;
            end
            m_last = NLANE - 1; m_owner = 0; m_waited = 0; m_act = M_IDLE;
            m_refund = '0; model_valid = 1'b1;
        end else begin
            // requests are judged against the pending set as it stood before this edge
            for (int i = 0; i < NLANE; i++) begin
                m_acc[i] = vend_req[i] && !m_pend[i] && m_stock[i] > 0;
                m_ref[i] = vend_req[i] && !m_pend[i] && m_stock[i] == 0;
            end
            case (m_act)
                M_IDLE: begin
                    found = 1'b0;
                    for (int k = 1; k <= NLANE; k++) begin
                        lane_k = (m_last + k) % NLANE;
                        if (!found && m_pend[lane_k]) begin
                            found = 1'b1; m_owner = lane_k; m_act = M_MOTOR; m_waited = 0;
                        end
                    end
                end
                M_MOTOR: begin
                    if (motor_done) begin
                        m_act = m_chg[m_owner] ? M_CHANGE : M_FINISH; m_waited = 0;
                    end else begin
                        m_waited++;
                        if (m_waited == TIMEOUT) m_act = M_FAULT;
                    end
                end
                M_CHANGE: begin
                    if (chg_done) m_act = M_FINISH;
                    else begin
                        m_waited++;
                        if (m_waited == TIMEOUT) m_act = M_FAULT;
                    end
                end
                M_FINISH: begin
                    m_pend[m_owner] = 1'b0; m_chg[m_owner] = 1'b0;
                    m_last = m_owner; m_act = M_IDLE;
                end
                M_FAULT: if (fault_clr) m_act = M_IDLE;
                default: m_act = M_IDLE;
            endcase
            for (int i = 0; i < NLANE; i++) begin
                if (m_acc[i]) begin m_pend[i] = 1'b1; m_chg[i] = vend_chg[i]; end
                if (restock_stb && int'(restock_lane) == i) m_stock[i] = STOCK_INIT;
                else if (m_acc[i]) m_stock[i]--;
            end
            m_refund = m_ref;
        end
        x_motor_go = (m_act == M_MOTOR);
        x_chg_go   = (m_act == M_CHANGE);
        x_fault    = (m_act == M_FAULT);
        x_busy     = (m_act != M_IDLE);
        x_served   = (m_act == M_FINISH) ? (NLANE'(1) << m_owner) : '0;
        for (int i = 0; i < NLANE; i++) x_empty[i] = (m_stock[i] == 0);
    end

    // ---------------- compare process + served-order scoreboard ----------------
    initial begin
        logic [LW-1:0] sb_lane;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("motor_go", 32'(motor_go), 32'(x_motor_go));
                chk("chg_go",   32'(chg_go),   32'(x_chg_go));
                chk("fault",    32'(fault),    32'(x_fault));
                chk("busy",     32'(busy),     32'(x_busy));
                chk("served",   32'(served),   32'(x_served));
                chk("refund",   32'(refund),   32'(m_refund));
                chk("empty",    32'(empty),    32'(x_empty));
                if (x_motor_go || x_chg_go) chk("motor_lane", 32'(motor_lane), 32'(m_owner));
                if (served !== '0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL served_order: unexpected served=%b at %0t", served, $time);
                    end else begin
                        sb_lane = exp_q.pop_front();
                        chk("served_order", 32'(served), 32'(1) << sb_lane);
                    end
                end
            end
        end
    end

    // ---------------- mechanism responder ----------------
    int motor_delay = 0, chg_delay = 0;
    bit motor_withhold = 1'b0, chg_withhold = 1'b0;

    initial begin
        int mcnt, ccnt;
        mcnt = 0; ccnt = 0;
        motor_done = 1'b0; chg_done = 1'b0;
        forever begin
            @(negedge clk);
            if (motor_go === 1'b1) mcnt++; else mcnt = 0;
            if (chg_go === 1'b1)   ccnt++; else ccnt = 0;
            motor_done = !motor_withhold && mcnt == motor_delay + 1;
            chg_done   = !chg_withhold && ccnt == chg_delay + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic vend(input logic [NLANE-1:0] req, input logic [NLANE-1:0] chg);
        @(negedge clk); vend_req = req; vend_chg = chg;
        @(negedge clk); vend_req = '0; vend_chg = '0;
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic clear_fault();
        @(negedge clk); fault_clr = 1'b1;
        @(negedge clk); fault_clr = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy !== 1'b0 || model_has_pend()) && n < max_cyc) begin
            @(negedge clk); n++;
        end
        if (n >= max_cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles at %0t", n, $time);
        end
    endtask

    task automatic run_to_fault(input string name, input bit on_chg, input int max_cyc);
        int hi = 0;
        int n = 0;
        while (fault !== 1'b1 && n < max_cyc) begin
            @(negedge clk); n++;
            if ((on_chg ? chg_go : motor_go) === 1'b1) hi++;
        end
        chk(name, 32'(hi), 32'(TIMEOUT));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst = 1'b1; vend_req = '0; vend_chg = '0;
        restock_stb = 1'b0; restock_lane = '0; fault_clr = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({motor_go, chg_go, fault, busy, served, refund, empty}), 32'(0));
        @(negedge clk); rst = 1'b0;

        // single vend on lane 2, no change, motor_done three cycles after motor_go rises
        motor_delay = 3;
        exp_q.push_back(2'd2);
        vend(4'b0100, 4'b0000);
        @(negedge clk);
        chk("t1_motor_latency", 32'(motor_go), 32'(1));
        chk("t1_motor_lane", 32'(motor_lane), 32'(2));
        repeat (4) @(negedge clk);
        chk("t1_served", 32'(served), 32'(4'b0100));
        chk("t1_motor_dropped", 32'(motor_go), 32'(0));
        chk("t1_model_stock2", 32'(m_stock[2]), 32'(9));
        wait_idle(20);

        // last is lane 2, so the scan restarts at lane 3 and wraps
        motor_delay = 0;
        exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        vend(4'b1011, 4'b0000);
        wait_idle(40);

        // after reset lane 0 wins first; all three owe change
        pulse_rst();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        vend(4'b1011, 4'b1011);
        wait_idle(40);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        vend(4'b0011, 4'b0000);
        wait_idle(40);

        // drain lane 1 to zero; a repeat while the last unit is pending is ignored
        pulse_rst();
        for (int i = 0; i < STOCK_INIT - 1; i++) begin
            exp_q.push_back(2'd1);
            vend(4'b0010, 4'b0000);
            wait_idle(20);
        end
        exp_q.push_back(2'd1);
        vend(4'b0010, 4'b0000);
        vend(4'b0010, 4'b0000);
        chk("t3_no_refund_pending", 32'(refund), 32'(0));
        wait_idle(20);
        chk("t3_empty", 32'(empty), 32'(4'b0010));
        vend(4'b0010, 4'b0000);
        chk("t3_refund", 32'(refund), 32'(4'b0010));
        chk("t3_still_idle", 32'(busy), 32'(0));
        @(negedge clk); restock_stb = 1'b1; restock_lane = 2'd1;
        @(negedge clk); restock_stb = 1'b0;
        chk("t3_restocked", 32'(empty), 32'(0));
        chk("t3_model_stock1", 32'(m_stock[1]), 32'(STOCK_INIT));

        // motor timeout on lane 0; lane 2 requests during FAULT; retry order follows last=1
        motor_withhold = 1'b1;
        vend(4'b0001, 4'b0000);
        run_to_fault("t4_motor_cycles_before_fault", 1'b0, 60);
        chk("t4_motor_off_in_fault", 32'(motor_go), 32'(0));
        vend(4'b0100, 4'b0000);
        chk("t4_fault_held", 32'(fault), 32'(1));
        motor_withhold = 1'b0;
        exp_q.push_back(2'd2); exp_q.push_back(2'd0);
        clear_fault();
        wait_idle(40);

        // change-unit timeout on lane 2, then retried once
        chg_withhold = 1'b1;
        vend(4'b0100, 4'b0100);
        run_to_fault("t5_chg_cycles_before_fault", 1'b1, 60);
        chg_withhold = 1'b0;
        exp_q.push_back(2'd2);
        clear_fault();
        wait_idle(40);

        // motor_done lands in the very cycle the timeout would fire
        motor_delay = TIMEOUT - 1;
        exp_q.push_back(2'd3);
        vend(4'b1000, 4'b0000);
        wait_idle(60);
        chk("t6_no_fault_exact", 32'(fault), 32'(0));
        motor_delay = 0;

        // reset while chg_go is high drops everything without a served pulse
        chg_withhold = 1'b1;
        vend(4'b0010, 4'b0010);
        n = 0;
        while (chg_go !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("t7_chg_go_reached", 32'(chg_go), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("t7_after_rst", 32'({chg_go, motor_go, busy, served, empty}), 32'(0));
        rst = 1'b0;
        chg_withhold = 1'b0;
        repeat (6) @(negedge clk);
        chk("t7_pend_dropped", 32'(busy), 32'(0));

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/vend_dispense_arbiter.md
# vend_dispense_arbiter

Shares one product-dispense motor and one change-return unit among NLANE coin-accumulator lane FSMs. Each lane reports a completed purchase with a one-cycle vend pulse plus a change flag. This block queues the requests, grants the mechanism round-robin, and sequences the motor and change handshakes with timeouts. It also tracks per-lane stock and refuses vends from empty lanes.

## Interface
Parameters:
- NLANE, 4, number of lane FSMs; LW = $clog2(NLANE)
- STOCK_W, 4, stock counter width per lane
- STOCK_INIT, 10, stock loaded at reset and on restock (must fit STOCK_W)
- TIMEOUT, 15, max cycles waiting for motor_done / chg_done

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- vend_req  in  NLANE  one-cycle purchase pulse per lane
- vend_chg  in  NLANE  change owed, qualified by vend_req of same lane
- motor_go  out  1  level, dispense command
- motor_lane  out  LW  lane being dispensed, valid while motor_go or chg_go
- motor_done  in  1  dispense complete, sampled only in DISP
- chg_go  out  1  level, return one change coin
- chg_done  in  1  change returned, sampled only in CHG
- served  out  NLANE  one-hot one-cycle pulse, vend completed
- refund  out  NLANE  one-cycle pulse, vend refused (lane empty)
- empty  out  NLANE  stock[i]==0
- restock_stb  in  1  reload stock of restock_lane to STOCK_INIT
- restock_lane  in  LW  lane to restock
- fault  out  1  level, mechanism timeout
- fault_clr  in  1  leave FAULT
- busy  out  1  state != IDLE

## Operation
- Request capture, every state incl. FAULT: vend_req[i] with stock[i]!=0 sets pend[i] and sets pend_chg[i] = vend_chg[i]. With stock[i]==0, pend is not set and refund[i] pulses next cycle. A request on a lane already pending is ignored: pend_chg is unchanged and no refund is issued.
- Stock is counted including pending vends: stock[i] decrements when the request is accepted. This makes a second accept on the last unit impossible.
- States:
  - IDLE: if any pend bit is set, select the first pending lane scanning from (last+1) mod NLANE, latch it into cur, and go to DISP.
  - DISP: motor_go=1, motor_lane=cur. On motor_done go to CHG if pend_chg[cur], else DONE. On timeout go to FAULT.
  - CHG: chg_go=1. On chg_done go to DONE. On timeout go to FAULT.
  - DONE: one cycle. served[cur]=1, pend[cur] and pend_chg[cur] cleared, last=cur, then go to IDLE.
  - FAULT: fault=1, no commands issued, pend and cur kept. On fault_clr go to IDLE. The interrupted lane stays pending and is retried with normal round-robin order from last.
- Timeout counter: cleared on entering DISP or CHG and incremented each cycle in those states. Timeout fires when the counter equals TIMEOUT-1 and done is low. If done is high in that same cycle, done wins.
- Restock: restock_stb loads STOCK_INIT into restock_lane. If it coincides with an accept on the same lane, the restock wins and no decrement is applied.
- Coinciding set and clear: vend_req[cur] in the DONE cycle is ignored, because pend[cur] is still set.
- Reset values:
  - state=IDLE, pend=0, pend_chg=0, cur=0.
  - last=NLANE-1, so lane 0 wins first.
  - All stock=STOCK_INIT.
  - motor_go=chg_go=fault=busy=0; served=refund=0.
  - empty=0 (for STOCK_INIT>0).
- Reset mid-operation drops motor_go/chg_go at the next edge and discards all pending vends. No served or refund pulse is issued.

## Timing
- All outputs are registered from state/counters; there is no combinational path from inputs to outputs.
- vend_req at edge t: pend visible in cycle t+1. If IDLE in t+1, motor_go is high from cycle t+2.
- motor_done high in cycle k: motor_go low at k+1.
  - With change: chg_go high at k+1, and chg_done at m gives served at m+1.
  - Without change: served at k+1.
- Minimum lane-to-lane spacing, with done returned immediately: IDLE, DISP, DONE, IDLE = 3 cycles per vend without change, 4 with change.
- refund[i] pulses exactly one cycle after the refused vend_req.
- fault rises on the edge after the timeout cycle and holds until fault_clr; IDLE follows the next cycle.

## Test plan
- Single vend, lane 2, vend_chg=0, motor_done 3 cycles after motor_go rises -> motor_lane=2, served=4'b0100 one cycle after done, stock[2]=9, chg_go never asserted.
- Lanes 0,1,3 request in the same cycle, all with change -> grant order 0,1,3; each serves DISP then CHG; three served pulses; last=3. A new lane-0 request then goes before lane 1.
- STOCK_INIT=2, lane 1 requests 3 times -> two served, third gives refund=4'b0010 and empty[1]=1. restock_stb lane 1 -> empty[1]=0, stock=2.
- motor_done withheld -> fault high after TIMEOUT cycles, motor_go low. fault_clr -> lane re-dispensed, served once only.
- motor_done asserted exactly in the timeout cycle -> no fault, normal completion.
- rst pulsed while chg_go high -> next cycle chg_go=0, busy=0, pend=0, stock back to STOCK_INIT, no served pulse.
